// File: rtl/reorder_buffer_pkg.sv
// Shared widths and entry layout for the reorder buffer.
// The widths match the register file's w64/w32/w8 commit-channel types.
package reorder_buffer_pkg;

    localparam int TAG_W  = 64;
    localparam int DATA_W = 32;
    localparam int LREG_W = 8;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              has_dest;
        logic [LREG_W-1:0] dest_logic;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } RobEntry;

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrapping pointer for the reorder buffer ring.
// A synchronous clear takes priority over the increment.
module rob_ptr #(
    parameter int W = 4
) (
    input  logic         i_clock,
    input  logic         i_nreset,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    // The counter is exactly W bits wide, so wrapping modulo 2**W needs no compare.
    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_ptr <= '0;
        end else if (i_clear) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer feeding the register file's commit channel.
// Entries are allocated at dispatch, marked done on write-back and retired oldest-first.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              flash,
    input  logic              dispatch_en,
    input  logic              dispatch_dest_en,
    input  logic [LREG_W-1:0] dispatch_dest_logic,
    output logic              dispatch_ready,
    output logic [TAG_W-1:0]  dispatch_tag,
    input  logic              complete_en,
    input  logic [TAG_W-1:0]  complete_tag,
    input  logic [DATA_W-1:0] complete_data,
    output logic              commit_en,
    output logic [LREG_W-1:0] commit_dest_logic,
    output logic [DATA_W-1:0] commit_data,
    input  logic              commit_reject
);

    localparam int               IDX_W      = $clog2(DEPTH);
    localparam logic [IDX_W:0]   FULL_COUNT = DEPTH[IDX_W:0];
    localparam logic [IDX_W:0]   CNT_ONE    = 1;

    RobEntry            r_entries [DEPTH];
    logic [IDX_W:0]     r_count;
    logic [TAG_W-1:0]   r_tagGen;

    logic [IDX_W-1:0]   w_head;
    logic [IDX_W-1:0]   w_tail;
    logic [IDX_W-1:0]   w_compIdx;
    logic               w_dispatchReady;
    logic               w_dispatchFire;
    logic               w_compAccept;
    logic               w_headCandidate;
    logic               w_commitEn;
    logic               w_retire;

    rob_ptr #(.W(IDX_W)) u_headPtr (
        .i_clock  (clock),
        .i_nreset (nreset),
        .i_clear  (flash),
        .i_inc    (w_retire),
        .o_ptr    (w_head)
    );

    rob_ptr #(.W(IDX_W)) u_tailPtr (
        .i_clock  (clock),
        .i_nreset (nreset),
        .i_clear  (flash),
        .i_inc    (w_dispatchFire),
        .o_ptr    (w_tail)
    );

    assign w_dispatchReady = (r_count != FULL_COUNT);
    assign w_dispatchFire  = dispatch_en && w_dispatchReady && !flash;

    // Tags are handed out in step with the tail, so the low tag bits name the slot.
    assign w_compIdx    = complete_tag[IDX_W-1:0];
    assign w_compAccept = complete_en && !flash
                       && r_entries[w_compIdx].valid
                       && !r_entries[w_compIdx].done
                       && (r_entries[w_compIdx].tag == complete_tag);

    assign w_headCandidate = r_entries[w_head].valid && r_entries[w_head].done;
    assign w_commitEn      = w_headCandidate && r_entries[w_head].has_dest;
    assign w_retire        = !flash && w_headCandidate
                          && (!r_entries[w_head].has_dest || !commit_reject);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else if (flash) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
        end else begin
            if (w_dispatchFire) begin
                r_entries[w_tail] <= '{valid:      1'b1,
                                       done:       1'b0,
                                       has_dest:   dispatch_dest_en,
                                       dest_logic: dispatch_dest_logic,
                                       tag:        r_tagGen,
                                       data:       '0};
            end
            if (w_compAccept) begin
                r_entries[w_compIdx].done <= 1'b1;
                r_entries[w_compIdx].data <= complete_data;
            end
            if (w_retire) begin
                r_entries[w_head].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_count  <= '0;
            r_tagGen <= '0;
        end else if (flash) begin
            r_count  <= '0;
            r_tagGen <= '0;
        end else begin
            if (w_dispatchFire) begin
                r_tagGen <= r_tagGen + 64'd1;
            end
            unique case ({w_dispatchFire, w_retire})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Message fields read the held head entry, so they stay put while rejected.
    assign dispatch_ready    = w_dispatchReady;
    assign dispatch_tag      = r_tagGen;
    assign commit_en         = w_commitEn;
    assign commit_dest_logic = w_commitEn ? r_entries[w_head].dest_logic : '0;
    assign commit_data       = w_commitEn ? r_entries[w_head].data       : '0;

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer that drives the commit side of the register file's `Message` commit channel. Each renamed instruction is allocated one entry at dispatch, and the entry's 64-bit tag is handed to the register file as `dest_phys`. Write-back completions mark entries done, and the oldest done entry is presented as a commit message carrying `dest_logic` and `data`. The block sits between dispatch/rename and the register file. It is the producer that the register file's commit receiver consumes.

## Interface
- `DEPTH`, 16: entry count; must be a power of two, at least 2.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `nreset`  in  1: asynchronous, active-low reset.
- `flash`  in  1: synchronous pipeline flush; dominates every other input.
- `dispatch_en`  in  1: allocate one entry this cycle.
- `dispatch_dest_en`  in  1: the entry writes a logical register.
- `dispatch_dest_logic`  in  8: destination logical register.
- `dispatch_ready`  out  1: at least one entry is free.
- `dispatch_tag`  out  64: tag that will be given to the next allocation; feeds `dest_phys`.
- `complete_en`  in  1: a write-back result is valid.
- `complete_tag`  in  64: tag of the completing instruction.
- `complete_data`  in  32: result value.
- `commit_en`  out  1: a commit message is valid.
- `commit_dest_logic`  out  8: logical register being retired.
- `commit_data`  out  32: architectural value to write.
- `commit_reject`  in  1: receiver refuses the message this cycle.

## Operation
- State:
  - entry array; each entry holds `valid`, `done`, `has_dest`, `dest_logic[7:0]`, `tag[63:0]`, `data[31:0]`.
  - `head` and `tail` pointers, each log2(DEPTH) bits.
  - `count`, log2(DEPTH)+1 bits.
  - `tag_gen[63:0]`.
- Reset and flash: all `valid` cleared, head = tail = count = 0, `tag_gen` = 0. This matches the register file, which zeroes its own tag generator on `flash`.
- Dispatch fires when `dispatch_en && dispatch_ready && !flash`:
  - entry[tail] gets valid=1, done=0, has_dest, dest_logic, and tag=`tag_gen`.
  - tail increments, wrapping modulo DEPTH; `tag_gen` increments (64-bit wrap is allowed).
  - `dispatch_en` while not ready is ignored, and no state changes.
- Completion: index = `complete_tag[log2(DEPTH)-1:0]`.
  - It is accepted only if entry[index] is valid, not done, and its stored tag equals `complete_tag`. The entry then gets done=1 and data=`complete_data`.
  - Anything else (stale tag, tag of a flushed entry, duplicate completion) is silently dropped.
- Head retirement: the head is a candidate when entry[head] is valid and done.
  - If `has_dest`=1, `commit_en`=1 and the head retires only on a cycle with `!commit_reject`.
  - If `has_dest`=0, `commit_en`=0 and the head retires unconditionally; no message is sent.
  - On retire: valid cleared, head increments with wrap, count decrements.
- At most one dispatch, one completion and one retirement per cycle.
- `count` next = count + dispatch − retire. A simultaneous dispatch and retire leaves `count` unchanged.
- Message fields `commit_dest_logic`/`commit_data` are held stable while `commit_en`=1 and `commit_reject`=1.

## Timing
- Values after reset:

  | Output | Reset value |
  |---|---|
  | `dispatch_ready` | 1 |
  | `dispatch_tag` | 0 |
  | `commit_en` | 0 |
  | `commit_dest_logic` | 0 |
  | `commit_data` | 0 |

- All outputs are combinational from registered state only. There is no input-to-output combinational path, so `commit_reject` never feeds back into `commit_en` within the same cycle.
- Completion accepted at edge t makes `commit_en` visible in the cycle after edge t, provided the entry is the head. Minimum dispatch→commit is 2 edges.
- `dispatch_ready` = (count != DEPTH), evaluated on registered `count`.
  - When full, a same-cycle retire does not make room for a dispatch in that cycle.
  - `dispatch_ready` rises the cycle after the retire.
- A completion targeting the head entry and a retirement of that same head cannot coincide, because retirement requires done=1 already.
- `flash` during a pending commit (`commit_en`=1 and rejected) drops the message; `commit_en`=0 the next cycle.
- `nreset` asserted mid-operation clears state immediately, without waiting for a clock edge.

## Structure
- The shared package holds:
  - the `RobEntry` struct;
  - `TAG_W`=64, `DATA_W`=32, `LREG_W`=8. The same widths are used by the register file's `w64`/`w32`/`w8` types.
- One sub-module, `rob_ptr`: a wrapping pointer counter with synchronous clear and an increment enable. It is instantiated twice, once for head and once for tail.
- The entry array stays in the top-level module.

## Test plan
- Reset, then dispatch 3 entries with dests 5/6/7:
  - `dispatch_tag` shows 0, 1, 2 and then 3.
  - Complete tags 0, 1, 2 with data 0xA/0xB/0xC.
  - Required: `commit_en` pulses 3 consecutive cycles, carrying (5,0xA), (6,0xB), (7,0xC).
- Out-of-order completion: dispatch tags 0–2, complete 2 then 1 then 0.
  - Required: no commit before tag 0 completes.
  - Then commits occur in order 0, 1, 2.
- Backpressure: hold `commit_reject`=1 for 4 cycles with the head done.
  - Required: `commit_en` stays 1 with the message unchanged for those cycles.
  - Retire happens on the first cycle with reject=0.
- Full and wrap, DEPTH=16:
  - Dispatch 16 entries; `dispatch_ready`=0, and a 17th dispatch is ignored.
  - Retire 1 entry; the next dispatch receives tag 16 in index 0.
- Stale completion: dispatch tag 0, `flash`, dispatch again (new tag 0, dest 9), then complete tag 16.
  - Required: the completion is dropped and no commit occurs.
  - Completing tag 0 with 0x55 then commits (9,0x55).
- No-dest entry: dispatch with `dispatch_dest_en`=0, then complete it.
  - Required: it retires with `commit_en`=0 throughout, and `count` returns to 0.
